// File: rtl/stopwatch_pkg.sv
// Shared constants, mode encoding and the packed time type for the stopwatch/timer datapath.
// Time struct fields are sized for the widest supported configuration; the top slices to its port widths.
package stopwatch_pkg;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    localparam int MSEC_FW = 16;
    localparam int HOUR_FW = 5;

    typedef struct packed {
        logic [HOUR_FW-1:0] hour;
        logic [5:0]         min;
        logic [5:0]         sec;
        logic [MSEC_FW-1:0] msec;
    } time_t;

endpackage

// File: rtl/stopwatch_timer_dp_if.sv
// Control/preload inputs and time/lap outputs of the stopwatch datapath.
// master = control FSM side, slave = datapath side.
interface stopwatch_timer_dp_if #(
    parameter int MSEC_W = 7,
    parameter int HOUR_W = 5
);
    logic              i_run;
    logic              i_clear;
    logic              i_mode;
    logic              i_load;
    logic              i_lap;
    logic [MSEC_W-1:0] i_ld_msec;
    logic [5:0]        i_ld_sec;
    logic [5:0]        i_ld_min;
    logic [HOUR_W-1:0] i_ld_hour;

    logic [MSEC_W-1:0] msec;
    logic [5:0]        sec;
    logic [5:0]        min;
    logic [HOUR_W-1:0] hour;
    logic [MSEC_W-1:0] lap_msec;
    logic [5:0]        lap_sec;
    logic [5:0]        lap_min;
    logic [HOUR_W-1:0] lap_hour;
    logic              o_lap_valid;
    logic              o_done;

    modport master (
        output i_run, i_clear, i_mode, i_load, i_lap,
        output i_ld_msec, i_ld_sec, i_ld_min, i_ld_hour,
        input  msec, sec, min, hour,
        input  lap_msec, lap_sec, lap_min, lap_hour, o_lap_valid, o_done
    );

    modport slave (
        input  i_run, i_clear, i_mode, i_load, i_lap,
        input  i_ld_msec, i_ld_sec, i_ld_min, i_ld_hour,
        output msec, sec, min, hour,
        output lap_msec, lap_sec, lap_min, lap_hour, o_lap_valid, o_done
    );
endinterface

// File: rtl/stopwatch_timer_dp_tick_gen.sv
// Prescaler that divides clk by DIV and emits a registered one-cycle tick.
// Holds while disabled; the synchronous clear zeroes both count and tick.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (enable) begin
            if (count == CW'(DIV - 1)) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + CW'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/stopwatch_timer_dp.sv
// Hundredths/seconds/minutes/hours up/down counter with preload, terminal detect and lap capture.
// Lap capture is built only when STOPWATCH_LAP_EN is defined; otherwise lap outputs are tied to 0.
module stopwatch_timer_dp
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100,
    parameter int HOUR_MAX = 24
) (
    input logic                 clk,
    input logic                 reset_n,
    stopwatch_timer_dp_if.slave bus
);
    localparam int MSEC_W = $clog2(TICK_HZ);
    localparam int HOUR_W = $clog2(HOUR_MAX);
    localparam int DIV    = CLK_FREQ / TICK_HZ;

    localparam logic [MSEC_FW-1:0] MSEC_TOP = MSEC_FW'(TICK_HZ - 1);
    localparam logic [HOUR_FW-1:0] HOUR_TOP = HOUR_FW'(HOUR_MAX - 1);

    time_t              cur;
    time_t              ld;
    logic               done;
    logic               tick;
    logic               all_zero;
    logic               last_step;
    logic [MSEC_FW-1:0] ld_msec_ext;
    logic [HOUR_FW-1:0] ld_hour_ext;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (bus.i_run && !done),
        .clear  (bus.i_clear || bus.i_load),
        .tick   (tick)
    );

    assign ld_msec_ext = MSEC_FW'(bus.i_ld_msec);
    assign ld_hour_ext = HOUR_FW'(bus.i_ld_hour);

    // Preload values saturate at each field's maximum rather than wrapping.
    always_comb begin
        ld      = '0;
        ld.msec = (ld_msec_ext > MSEC_TOP) ? MSEC_TOP : ld_msec_ext;
        ld.sec  = (bus.i_ld_sec > SEC_MAX) ? SEC_MAX : bus.i_ld_sec;
        ld.min  = (bus.i_ld_min > MIN_MAX) ? MIN_MAX : bus.i_ld_min;
        ld.hour = (ld_hour_ext > HOUR_TOP) ? HOUR_TOP : ld_hour_ext;
    end

    assign all_zero  = (cur == '0);
    assign last_step = (cur.msec == MSEC_FW'(1)) && (cur.sec == '0) &&
                       (cur.min == '0) && (cur.hour == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur  <= '0;
            done <= 1'b0;
        end else if (bus.i_clear) begin
            cur  <= '0;
            done <= 1'b0;
        end else if (bus.i_load) begin
            cur  <= ld;
            done <= 1'b0;
        end else if (tick && !done) begin
            case (bus.i_mode)
                MODE_UP: begin
                    if (cur.msec == MSEC_TOP) begin
                        cur.msec <= '0;
                        if (cur.sec == SEC_MAX) begin
                            cur.sec <= '0;
                            if (cur.min == MIN_MAX) begin
                                cur.min  <= '0;
                                cur.hour <= (cur.hour == HOUR_TOP) ? '0 : cur.hour + HOUR_FW'(1);
                            end else begin
                                cur.min <= cur.min + 6'd1;
                            end
                        end else begin
                            cur.sec <= cur.sec + 6'd1;
                        end
                    end else begin
                        cur.msec <= cur.msec + MSEC_FW'(1);
                    end
                end
                MODE_DOWN: begin
                    // A tick at 0:00:00.00 only flags completion; the fields stay put.
                    if (all_zero) begin
                        done <= 1'b1;
                    end else begin
                        if (cur.msec != '0) begin
                            cur.msec <= cur.msec - MSEC_FW'(1);
                        end else begin
                            cur.msec <= MSEC_TOP;
                            if (cur.sec != '0) begin
                                cur.sec <= cur.sec - 6'd1;
                            end else begin
                                cur.sec <= SEC_MAX;
                                if (cur.min != '0) begin
                                    cur.min <= cur.min - 6'd1;
                                end else begin
                                    cur.min  <= MIN_MAX;
                                    cur.hour <= cur.hour - HOUR_FW'(1);
                                end
                            end
                        end
                        if (last_step) begin
                            done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.msec   = cur.msec[MSEC_W-1:0];
    assign bus.sec    = cur.sec;
    assign bus.min    = cur.min;
    assign bus.hour   = cur.hour[HOUR_W-1:0];
    assign bus.o_done = done;

`ifdef STOPWATCH_LAP_EN
    time_t lap;
    logic  lap_valid;

    // Lap samples the time as it was before this cycle's update, so a coincident tick is excluded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lap       <= '0;
            lap_valid <= 1'b0;
        end else if (bus.i_clear) begin
            lap       <= '0;
            lap_valid <= 1'b0;
        end else if (bus.i_lap) begin
            lap       <= cur;
            lap_valid <= 1'b1;
        end
    end

    assign bus.lap_msec    = lap.msec[MSEC_W-1:0];
    assign bus.lap_sec     = lap.sec;
    assign bus.lap_min     = lap.min;
    assign bus.lap_hour    = lap.hour[HOUR_W-1:0];
    assign bus.o_lap_valid = lap_valid;
`else
    assign bus.lap_msec    = '0;
    assign bus.lap_sec     = '0;
    assign bus.lap_min     = '0;
    assign bus.lap_hour    = '0;
    assign bus.o_lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer_dp.sv
// Self-checking bench for stopwatch_timer_dp: a total-hundredths reference model compared every cycle,
// plus directed literal checks; lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_timer_dp;
    import stopwatch_pkg::*;

    localparam int CLK_FREQ = 1000;
    localparam int TICK_HZ  = 100;
    localparam int HOUR_MAX = 24;
    localparam int DIV      = CLK_FREQ / TICK_HZ;
    localparam int MSEC_W   = 7;
    localparam int HOUR_W   = 5;
    localparam int TOTAL    = HOUR_MAX * 3600 * TICK_HZ;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    stopwatch_timer_dp_if #(.MSEC_W(MSEC_W), .HOUR_W(HOUR_W)) bus ();

    stopwatch_timer_dp #(
        .CLK_FREQ(CLK_FREQ),
        .TICK_HZ (TICK_HZ),
        .HOUR_MAX(HOUR_MAX)
    ) dut (
        .clk    (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference state: time as a single count of hundredths since 0:00:00.00.
    int m_time = 0;
    int m_pre  = 0;
    bit m_tick = 1'b0;
    bit m_done = 1'b0;
    int m_lap  = 0;
    bit m_lv   = 1'b0;

    function automatic int clampi(input int v, input int top);
        return (v > top) ? top : v;
    endfunction

    function automatic logic [63:0] pack_time(input int h, input int m, input int s, input int ms, input bit d);
        return {39'd0, 5'(h), 6'(m), 6'(s), 7'(ms), d};
    endfunction

    function automatic logic [63:0] pack_hund(input int t, input bit flag);
        return pack_time(t / 360000, (t / 6000) % 60, (t / 100) % 60, t % 100, flag);
    endfunction

    function automatic logic [63:0] act_time();
        return {39'd0, bus.hour, bus.min, bus.sec, bus.msec, bus.o_done};
    endfunction

    function automatic logic [63:0] act_lap();
        return {39'd0, bus.lap_hour, bus.lap_min, bus.lap_sec, bus.lap_msec, bus.o_lap_valid};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  old_time;
        bit  old_done;
        if (!rst_n) begin
            m_time = 0; m_pre = 0; m_tick = 1'b0; m_done = 1'b0; m_lap = 0; m_lv = 1'b0;
        end else begin
            old_time = m_time;
            old_done = m_done;
            if (bus.i_clear) begin
                m_time = 0; m_pre = 0; m_tick = 1'b0; m_done = 1'b0; m_lap = 0; m_lv = 1'b0;
            end else begin
                if (bus.i_load) begin
                    m_time = ((clampi(int'(bus.i_ld_hour), HOUR_MAX - 1) * 60 +
                               clampi(int'(bus.i_ld_min), 59)) * 60 +
                               clampi(int'(bus.i_ld_sec), 59)) * 100 +
                               clampi(int'(bus.i_ld_msec), TICK_HZ - 1);
                    m_pre  = 0;
                    m_tick = 1'b0;
                    m_done = 1'b0;
                end else begin
                    if (m_tick && !old_done) begin
                        if (bus.i_mode == MODE_DOWN) begin
                            if (m_time > 0) m_time = m_time - 1;
                            if (m_time == 0) m_done = 1'b1;
                        end else begin
                            m_time = (m_time + 1) % TOTAL;
                        end
                    end
                    if (bus.i_run && !old_done) begin
                        m_tick = (m_pre == DIV - 1);
                        m_pre  = (m_pre == DIV - 1) ? 0 : m_pre + 1;
                    end else begin
                        m_tick = 1'b0;
                    end
                end
`ifdef STOPWATCH_LAP_EN
                if (bus.i_lap) begin
                    m_lap = old_time;
                    m_lv  = 1'b1;
                end
`endif
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model_time", act_time(), pack_hund(m_time, m_done));
            checkOutput("model_lap", act_lap(), pack_hund(m_lap, m_lv));
        end
    end

    task automatic applyStimulus(input logic run, input logic clear, input logic mode, input logic load,
                                 input logic lap, input int h, input int m, input int s, input int ms);
        bus.i_run     = run;
        bus.i_clear   = clear;
        bus.i_mode    = mode;
        bus.i_load    = load;
        bus.i_lap     = lap;
        bus.i_ld_hour = HOUR_W'(h);
        bus.i_ld_min  = 6'(m);
        bus.i_ld_sec  = 6'(s);
        bus.i_ld_msec = MSEC_W'(ms);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(0, 0, MODE_UP, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_time", act_time(), pack_time(0, 0, 0, 0, 0));
        checkOutput("reset_lap", act_lap(), pack_time(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Up count from a fresh block: first change DIV+1 edges after run.
        applyStimulus(1, 0, MODE_UP, 0, 0, 0, 0, 0, 0);
        step(10);
        checkOutput("first_tick_pending", act_time(), pack_time(0, 0, 0, 0, 0));
        step(1);
        checkOutput("first_tick", act_time(), pack_time(0, 0, 0, 1, 0));
        step(990);
        checkOutput("hundred_ticks", act_time(), pack_time(0, 0, 1, 0, 0));

        // Full wrap from 23:59:59.99.
        applyStimulus(1, 0, MODE_UP, 1, 0, 23, 59, 59, 99);
        step(1);
        applyStimulus(1, 0, MODE_UP, 0, 0, 0, 0, 0, 0);
        checkOutput("load_max", act_time(), pack_time(23, 59, 59, 99, 0));
        step(10);
        checkOutput("wrap_pending", act_time(), pack_time(23, 59, 59, 99, 0));
        step(1);
        checkOutput("up_wrap", act_time(), pack_time(0, 0, 0, 0, 0));

        // Down count borrow chain, then clamped preload.
        applyStimulus(0, 0, MODE_DOWN, 1, 0, 1, 0, 0, 0);
        step(1);
        applyStimulus(1, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0);
        step(11);
        checkOutput("down_borrow", act_time(), pack_time(0, 59, 59, 99, 0));
        applyStimulus(0, 0, MODE_DOWN, 1, 0, 31, 63, 63, 127);
        step(1);
        applyStimulus(0, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0);
        checkOutput("load_clamp", act_time(), pack_time(23, 59, 59, 99, 0));

        // Terminal count, freeze, clear.
        applyStimulus(0, 0, MODE_DOWN, 1, 0, 0, 0, 0, 2);
        step(1);
        applyStimulus(1, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0);
        step(11);
        checkOutput("down_one_left", act_time(), pack_time(0, 0, 0, 1, 0));
        step(10);
        checkOutput("down_done", act_time(), pack_time(0, 0, 0, 0, 1));
        step(50);
        checkOutput("done_frozen", act_time(), pack_time(0, 0, 0, 0, 1));
        applyStimulus(0, 1, MODE_DOWN, 0, 0, 0, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0);
        checkOutput("clear_done", act_time(), pack_time(0, 0, 0, 0, 0));

        // Tick while already zero only raises done.
        applyStimulus(0, 0, MODE_DOWN, 1, 0, 0, 0, 0, 0);
        step(1);
        applyStimulus(1, 0, MODE_DOWN, 0, 0, 0, 0, 0, 0);
        step(11);
        checkOutput("zero_tick_done", act_time(), pack_time(0, 0, 0, 0, 1));
        applyStimulus(0, 1, MODE_UP, 0, 0, 0, 0, 0, 0);
        step(1);

        // Lap on the tick cycle captures the pre-tick time.
        applyStimulus(0, 0, MODE_UP, 1, 0, 0, 0, 3, 41);
        step(1);
        applyStimulus(1, 0, MODE_UP, 0, 0, 0, 0, 0, 0);
        step(10);
        applyStimulus(1, 0, MODE_UP, 0, 1, 0, 0, 0, 0);
        step(1);
        applyStimulus(1, 0, MODE_UP, 0, 0, 0, 0, 0, 0);
        checkOutput("lap_time_after", act_time(), pack_time(0, 0, 3, 42, 0));
`ifdef STOPWATCH_LAP_EN
        checkOutput("lap_capture", act_lap(), pack_time(0, 0, 3, 41, 1));
`else
        checkOutput("lap_disabled", act_lap(), pack_time(0, 0, 0, 0, 0));
`endif
        applyStimulus(1, 1, MODE_UP, 0, 1, 0, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, MODE_UP, 0, 0, 0, 0, 0, 0);
        checkOutput("lap_clear_time", act_time(), pack_time(0, 0, 0, 0, 0));
        checkOutput("lap_clear_lap", act_lap(), pack_time(0, 0, 0, 0, 0));

        // Asynchronous reset mid-run.
        applyStimulus(0, 0, MODE_UP, 1, 1, 0, 2, 17, 55);
        step(1);
        applyStimulus(1, 0, MODE_UP, 0, 0, 0, 0, 0, 0);
        step(3);
        checkOutput("pre_reset", act_time(), pack_time(0, 2, 17, 55, 0));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_time", act_time(), pack_time(0, 0, 0, 0, 0));
        checkOutput("async_reset_lap", act_lap(), pack_time(0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
